// File: rtl/sr_cmd_encoder.sv
// Drive side of an S/R flip-flop link: converts a handshaked target-Q stream into
// non-overlapping s/r pulses, skips redundant commands and checks q/qbar read-back.
module sr_cmd_encoder #(
    parameter int HOLD_CYCLES = 1,
    parameter int CHECK_LAT   = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    input  logic             qbar_fb,
    input  logic             err_clr,
    output logic             busy,
    output logic             shadow_q,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cmd_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] LAT_M1  = 16'(CHECK_LAT - 1);

    state_t           state, state_nxt;
    logic [15:0]      tmr, tmr_nxt;
    logic             exp_q, exp_nxt;
    logic             shadow_known, known_nxt;
    logic             shadow_nxt;
    logic             s_nxt, r_nxt;
    logic             ready_nxt, busy_nxt;
    logic             err_nxt;
    logic [1:0]       code_nxt, new_err;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tmr          <= '0;
            exp_q        <= 1'b0;
            shadow_known <= 1'b0;
            shadow_q     <= 1'b0;
            s            <= 1'b0;
            r            <= 1'b0;
            tgt_ready    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            cmd_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            exp_q        <= exp_nxt;
            shadow_known <= known_nxt;
            shadow_q     <= shadow_nxt;
            s            <= s_nxt;
            r            <= r_nxt;
            tgt_ready    <= ready_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
            err_code     <= code_nxt;
            cmd_cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        exp_nxt    = exp_q;
        known_nxt  = shadow_known;
        shadow_nxt = shadow_q;
        s_nxt      = s;
        r_nxt      = r;
        cnt_nxt    = cmd_cnt;
        new_err    = 2'b00;

        case (state)
            IDLE: begin
                s_nxt = 1'b0;
                r_nxt = 1'b0;
                if (tgt_valid && tgt_ready) begin
                    exp_nxt = tgt_bit;
                    tmr_nxt = '0;
                    if (shadow_known && (tgt_bit == shadow_q)) begin
                        state_nxt = CHECK;
                    end else begin
                        // s and r are complements of one bit, so they can never both be high
                        state_nxt = DRIVE;
                        s_nxt     = tgt_bit;
                        r_nxt     = ~tgt_bit;
                    end
                end
            end
            DRIVE: begin
                if (tmr == HOLD_M1) begin
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                    tmr_nxt   = '0;
                    state_nxt = SETTLE;
                end else begin
                    tmr_nxt = tmr + 16'd1;
                end
            end
            SETTLE: begin
                s_nxt = 1'b0;
                r_nxt = 1'b0;
                if (tmr == LAT_M1) begin
                    tmr_nxt   = '0;
                    state_nxt = CHECK;
                end else begin
                    tmr_nxt = tmr + 16'd1;
                end
            end
            CHECK: begin
                s_nxt      = 1'b0;
                r_nxt      = 1'b0;
                new_err    = {qbar_fb == q_fb, q_fb != exp_q};
                shadow_nxt = exp_q;
                known_nxt  = 1'b1;
                cnt_nxt    = cmd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                state_nxt  = IDLE;
            end
            default: begin
                s_nxt     = 1'b0;
                r_nxt     = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // a fresh error is OR-ed in after the clear so it is never lost
        code_nxt  = (err_clr ? 2'b00 : err_code) | new_err;
        err_nxt   = |code_nxt;
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_sr_cmd_encoder.sv
// Directed bench: two encoders (default timing, and HOLD=3/LAT=2/CNT_W=2) each driving a behavioural srff.
module tb_sr_cmd_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tv = '0, tbit = '0, clr = '0, fq = '0, tie = '0;
    logic [1:0] s_w, r_w, rdy, busy, shq, errw, q_fb, qbar_fb, sq;
    logic [1:0] code0, code1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_cmd_encoder #(.HOLD_CYCLES(1), .CHECK_LAT(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tv[0]), .tgt_bit(tbit[0]), .tgt_ready(rdy[0]),
        .s(s_w[0]), .r(r_w[0]), .q_fb(q_fb[0]), .qbar_fb(qbar_fb[0]), .err_clr(clr[0]),
        .busy(busy[0]), .shadow_q(shq[0]), .err(errw[0]), .err_code(code0), .cmd_cnt(cnt0)
    );

    sr_cmd_encoder #(.HOLD_CYCLES(3), .CHECK_LAT(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tv[1]), .tgt_bit(tbit[1]), .tgt_ready(rdy[1]),
        .s(s_w[1]), .r(r_w[1]), .q_fb(q_fb[1]), .qbar_fb(qbar_fb[1]), .err_clr(clr[1]),
        .busy(busy[1]), .shadow_q(shq[1]), .err(errw[1]), .err_code(code1), .cmd_cnt(cnt1)
    );

    // behavioural srff per DUT, with optional forced-low q and tied qbar faults
    always @(posedge clk or posedge rst) begin
        if (rst) sq <= 2'b00;
        else for (int i = 0; i < 2; i++) begin
            if (s_w[i]) sq[i] <= 1'b1;
            else if (r_w[i]) sq[i] <= 1'b0;
        end
    end
    assign q_fb    = sq & ~fq;
    assign qbar_fb = (tie & q_fb) | (~tie & ~q_fb);

    always @(negedge clk) begin
        checks++;
        if ((s_w & r_w) != 2'b00) begin
            errors++;
            $display("FAIL s_and_r_overlap actual=%b required=00", s_w & r_w);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] code_of(input int d);
        return (d == 0) ? code0 : code1;
    endfunction

    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? cnt0 : {6'b0, cnt1};
    endfunction

    // offers one bit, then measures s/r/busy lengths until the FSM is back in IDLE
    task automatic send(input int d, input logic b, output int slen, output int rlen, output int blen);
        int n;
        n = 0; slen = 0; rlen = 0; blen = 0;
        while (!rdy[d] && n < 100) begin @(negedge clk); n++; end
        if (!rdy[d]) chk("ready_timeout", 0, 1);
        tv[d] = 1'b1; tbit[d] = b;
        @(negedge clk);
        tv[d] = 1'b0;
        n = 0;
        while (busy[d] && n < 100) begin
            slen += int'(s_w[d]); rlen += int'(r_w[d]); blen++;
            @(negedge clk); n++;
        end
        if (busy[d]) chk("busy_timeout", 0, 1);
    endtask

    typedef struct {
        int         d;
        logic       b, f, c, t;
        int         es, er, eb;
        logic       ee;
        logic [1:0] ec;
        logic       esh;
        int         ecnt;
    } vec_t;

    function automatic vec_t mk(int d, logic b, logic f, logic c, logic t, int es, int er, int eb,
                                logic ee, logic [1:0] ec, logic esh, int ecnt);
        vec_t v;
        v.d = d; v.b = b; v.f = f; v.c = c; v.t = t; v.es = es; v.er = er; v.eb = eb;
        v.ee = ee; v.ec = ec; v.esh = esh; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t vt[13];

    task automatic run_vec(input int i);
        int sl, rl, bl, d;
        d = vt[i].d;
        fq[d] = vt[i].f; tie[d] = vt[i].t; clr[d] = vt[i].c;
        send(d, vt[i].b, sl, rl, bl);
        chk($sformatf("v%0d_s_len", i), sl, vt[i].es);
        chk($sformatf("v%0d_r_len", i), rl, vt[i].er);
        chk($sformatf("v%0d_busy_len", i), bl, vt[i].eb);
        chk($sformatf("v%0d_err", i), errw[d], vt[i].ee);
        chk($sformatf("v%0d_err_code", i), code_of(d), vt[i].ec);
        chk($sformatf("v%0d_shadow", i), shq[d], vt[i].esh);
        chk($sformatf("v%0d_cmd_cnt", i), cnt_of(d), vt[i].ecnt);
        chk($sformatf("v%0d_ready", i), rdy[d], 1);
        clr[d] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, spulse;
        // d  b  fq clr tie  s  r  busy err code shadow cnt
        vt[0]  = mk(0, 1, 0, 0, 0, 1, 0, 3, 0, 2'b00, 1, 1);
        vt[1]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 2);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 2'b00, 0, 3);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4);
        vt[4]  = mk(0, 1, 0, 0, 0, 1, 0, 3, 0, 2'b00, 1, 5);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 2'b00, 0, 6);
        vt[6]  = mk(0, 1, 1, 0, 0, 1, 0, 3, 1, 2'b01, 1, 7);
        vt[7]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 2'b01, 1, 8);
        vt[8]  = mk(1, 1, 0, 0, 0, 3, 0, 6, 0, 2'b00, 1, 1);
        vt[9]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 2);
        vt[10] = mk(1, 0, 0, 0, 1, 0, 3, 6, 1, 2'b10, 0, 3);
        vt[11] = mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 2'b10, 0, 0);
        vt[12] = mk(1, 1, 0, 0, 0, 3, 0, 6, 1, 2'b10, 1, 1);

        // reset state
        #12;
        chk("rst_ready0", rdy[0], 0);
        chk("rst_ready1", rdy[1], 0);
        chk("rst_sr0", {s_w[0], r_w[0]}, 0);
        chk("rst_busy0", busy[0], 0);
        chk("rst_err0", {errw[0], code0}, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_shadow0", shq[0], 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_ready0", rdy[0], 1);
        chk("post_rst_ready1", rdy[1], 1);

        // reset mid-DRIVE on the long-hold encoder
        tv[1] = 1'b1; tbit[1] = 1'b1;
        @(negedge clk);
        tv[1] = 1'b0;
        chk("middrive_s_high", s_w[1], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sr", {s_w[1], r_w[1]}, 0);
        chk("async_rst_busy", busy[1], 0);
        chk("async_rst_ready", rdy[1], 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_exit_ready", rdy[1], 1);
        chk("rst_exit_cnt", cnt1, 0);
        chk("rst_exit_busy", busy[1], 0);

        for (int i = 0; i <= 6; i++) run_vec(i);

        // err_clr alone clears the sticky error
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("clr_err", errw[0], 0);
        chk("clr_code", code0, 0);

        // err_clr held while a new error lands: set wins
        run_vec(7);

        // tgt_valid held high: one accept per IDLE cycle, skipped commands only
        fq[0] = 1'b0;
        tv[0] = 1'b1; tbit[0] = 1'b1;
        acc = 0; spulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (rdy[0] && tv[0]) acc++;
            spulse += int'(s_w[0] | r_w[0]);
            @(negedge clk);
        end
        tv[0] = 1'b0;
        chk("hold_accepts", acc, 6);
        chk("hold_cmd_cnt", cnt0, 14);
        chk("hold_no_pulse", spulse, 0);
        chk("hold_idle", busy[0], 0);

        for (int i = 8; i <= 12; i++) run_vec(i);
        tie[1] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
